// File: rtl/vreg_file_masked.sv
// Vector register file: NUM_REGS x LANES x WIDTH, two combinational read ports,
// one lane-masked synchronous write port, optional write bypass and a bulk-clear engine.
module vreg_file_masked #(
    parameter int NUM_REGS = 9,
    parameter int LANES    = 4,
    parameter int WIDTH    = 32,
    parameter int AW       = 4,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wren,
    input  logic [AW-1:0]    wraddr,
    input  logic [WIDTH-1:0] wrdata [LANES-1:0],
    input  logic [LANES-1:0] wrmask,
    input  logic [AW-1:0]    readAddr1,
    input  logic [AW-1:0]    readAddr2,
    output logic [WIDTH-1:0] r1v [0:LANES-1],
    output logic [WIDTH-1:0] r2v [0:LANES-1],
    input  logic             clr_start,
    output logic             clr_busy,
    output logic             clr_done,
    output logic             wr_drop
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // One extra bit so NUM_REGS == 2**AW still compares correctly.
    localparam logic [AW:0]   NREGS_EXT = (AW+1)'(NUM_REGS);
    localparam logic [AW-1:0] LAST_REG  = AW'(NUM_REGS - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic          clr_done_reg, clr_done_next;
    logic          wr_drop_reg, wr_drop_next;

    logic [WIDTH-1:0] mem_reg [NUM_REGS][LANES];

    logic wr_in_range;
    logic wr_accept;

    assign clr_busy    = (state_reg == CLEAR);
    assign clr_done    = clr_done_reg;
    assign wr_drop     = wr_drop_reg;

    assign wr_in_range = ({1'b0, wraddr} < NREGS_EXT);
    assign wr_accept   = wren && !clr_busy && wr_in_range;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        clr_done_next = 1'b0;
        wr_drop_next  = wren && (!wr_in_range || clr_busy);
        case (state_reg)
            IDLE: begin
                if (clr_start) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                // clr_start is deliberately ignored here: a running sweep never restarts.
                if (cnt_reg == LAST_REG) begin
                    state_next    = IDLE;
                    cnt_next      = '0;
                    clr_done_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            clr_done_reg <= 1'b0;
            wr_drop_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            clr_done_reg <= clr_done_next;
            wr_drop_reg  <= wr_drop_next;
        end
    end

    // Clear and write never collide: a write is only accepted outside CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                for (int l = 0; l < LANES; l++) begin
                    mem_reg[r][l] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (clr_busy && (cnt_reg == AW'(r))) begin
                    for (int l = 0; l < LANES; l++) begin
                        mem_reg[r][l] <= '0;
                    end
                end else if (wr_accept && (wraddr == AW'(r))) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (wrmask[l]) begin
                            mem_reg[r][l] <= wrdata[l];
                        end
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [WIDTH-1:0] rd1_next;
            logic [WIDTH-1:0] rd2_next;

            always_comb begin
                rd1_next = '0;
                rd2_next = '0;
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (readAddr1 == AW'(r)) begin
                        rd1_next = mem_reg[r][gi];
                    end
                    if (readAddr2 == AW'(r)) begin
                        rd2_next = mem_reg[r][gi];
                    end
                end
                if ((BYPASS != 0) && wr_accept && wrmask[gi]) begin
                    if (readAddr1 == wraddr) begin
                        rd1_next = wrdata[gi];
                    end
                    if (readAddr2 == wraddr) begin
                        rd2_next = wrdata[gi];
                    end
                end
                // Keep reads quiet while reset is held, even if a write is presented.
                if (!rst_n) begin
                    rd1_next = '0;
                    rd2_next = '0;
                end
            end

            assign r1v[gi] = rd1_next;
            assign r2v[gi] = rd2_next;
        end
    endgenerate

endmodule

// File: tb/tb_vreg_file_masked.sv
module tb_vreg_file_masked;

    localparam int NR = 9;
    localparam int LN = 4;
    localparam int W  = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wren;
    logic [AW-1:0] wraddr;
    logic [W-1:0]  wrdata [LN-1:0];
    logic [LN-1:0] wrmask;
    logic [AW-1:0] readAddr1, readAddr2;
    logic          clr_start;

    logic [W-1:0]  r1v [0:LN-1];
    logic [W-1:0]  r2v [0:LN-1];
    logic          clr_busy, clr_done, wr_drop;
    logic [W-1:0]  r1v_nb [0:LN-1];
    logic [W-1:0]  r2v_nb [0:LN-1];
    logic          clr_busy_nb, clr_done_nb, wr_drop_nb;

    int vectors     = 0;
    int miscompares = 0;
    logic saw_clr;
    logic test_done = 1'b0;

    localparam logic [W-1:0] A = 32'hAAAA_0000;
    localparam logic [W-1:0] B = 32'hBBBB_0001;
    localparam logic [W-1:0] C = 32'hCCCC_0002;
    localparam logic [W-1:0] D = 32'hDDDD_0003;
    localparam logic [W-1:0] F = 32'hFFFF_FFFF;

    always #5 clk = ~clk;

    vreg_file_masked #(.NUM_REGS(NR), .LANES(LN), .WIDTH(W), .AW(AW), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .wrmask(wrmask), .readAddr1(readAddr1), .readAddr2(readAddr2),
        .r1v(r1v), .r2v(r2v), .clr_start(clr_start), .clr_busy(clr_busy),
        .clr_done(clr_done), .wr_drop(wr_drop)
    );

    vreg_file_masked #(.NUM_REGS(NR), .LANES(LN), .WIDTH(W), .AW(AW), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .wrmask(wrmask), .readAddr1(readAddr1), .readAddr2(readAddr2),
        .r1v(r1v_nb), .r2v(r2v_nb), .clr_start(clr_start), .clr_busy(clr_busy_nb),
        .clr_done(clr_done_nb), .wr_drop(wr_drop_nb)
    );

    function automatic logic [4*W-1:0] pk(input logic [W-1:0] v [0:LN-1]);
        return {v[3], v[2], v[1], v[0]};
    endfunction

    function automatic logic [4*W-1:0] lv(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                          input logic [W-1:0] l2, input logic [W-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [W-1:0] fv(input int r, input int l);
        return 32'h0100_0000 * (r + 1) + 32'h10 * l + 32'h5;
    endfunction

    task automatic chk(input string tag, input logic [4*W-1:0] obs, input logic [4*W-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %0h expected %0h", vectors, tag, obs, exp);
    endtask

    task automatic set_data(input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [W-1:0] d3);
        wrdata[0] = d0;
        wrdata[1] = d1;
        wrdata[2] = d2;
        wrdata[3] = d3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        if (!test_done) begin
            miscompares++;
            $error("FAIL timeout: test did not complete in time");
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    initial begin
        rst_n = 1'b0; wren = 1'b0; wraddr = '0; wrmask = '0; clr_start = 1'b0;
        readAddr1 = 4'd0; readAddr2 = 4'd8;
        set_data(0, 0, 0, 0);

        #12;
        chk("rst_r1v", pk(r1v), lv(0, 0, 0, 0));
        chk("rst_r2v", pk(r2v), lv(0, 0, 0, 0));
        chk("rst_busy", clr_busy, 1'b0);
        chk("rst_done", clr_done, 1'b0);
        chk("rst_drop", wr_drop, 1'b0);
        wren = 1'b1; wraddr = 4'd0; wrmask = 4'hF; set_data(F, F, F, F);
        #1;
        chk("rst_no_bypass", pk(r1v), lv(0, 0, 0, 0));
        wren = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_r1v", pk(r1v), lv(0, 0, 0, 0));
        chk("post_rst_r2v", pk(r2v), lv(0, 0, 0, 0));

        wren = 1'b1; wraddr = 4'd3; wrmask = 4'hF; set_data(A, B, C, D);
        tick();
        set_data(1, 2, 3, 4); wrmask = 4'b0101; readAddr1 = 4'd3;
        #1;
        chk("mask_bypass", pk(r1v), lv(1, B, 3, D));
        chk("mask_nobypass", pk(r1v_nb), lv(A, B, C, D));
        tick();
        wren = 1'b0;
        #1;
        chk("mask_stored", pk(r1v_nb), lv(1, B, 3, D));
        chk("mask_stored_byp", pk(r1v), lv(1, B, 3, D));
        chk("mask_drop", wr_drop, 1'b0);
        wren = 1'b1; wrmask = 4'h0; set_data(F, F, F, F);
        tick();
        wren = 1'b0;
        #1;
        chk("mask0_hold", pk(r1v), lv(1, B, 3, D));
        chk("mask0_drop", wr_drop, 1'b0);

        wren = 1'b1; wraddr = 4'd5; wrmask = 4'hF; set_data(32'h11, 32'h11, 32'h11, 32'h11);
        tick();
        wrmask = 4'b0011; set_data(F, F, 32'hDEAD, 32'hDEAD);
        readAddr1 = 4'd5; readAddr2 = 4'd5;
        #1;
        chk("byp_r1v", pk(r1v), lv(F, F, 32'h11, 32'h11));
        chk("byp_r2v", pk(r2v), lv(F, F, 32'h11, 32'h11));
        chk("nobyp_r1v", pk(r1v_nb), lv(32'h11, 32'h11, 32'h11, 32'h11));
        tick();
        wren = 1'b0;
        #1;
        chk("nobyp_after", pk(r1v_nb), lv(F, F, 32'h11, 32'h11));

        wren = 1'b1; wraddr = 4'd12; wrmask = 4'hF; set_data(32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD);
        readAddr1 = 4'd3; readAddr2 = 4'd12;
        #1;
        chk("oor_read", pk(r2v), lv(0, 0, 0, 0));
        chk("oor_no_byp", pk(r1v), lv(1, B, 3, D));
        tick();
        wren = 1'b0;
        #1;
        chk("oor_drop", wr_drop, 1'b1);
        readAddr1 = 4'd4;
        #1;
        chk("oor_reg4", pk(r1v), lv(0, 0, 0, 0));
        readAddr1 = 4'd3;
        #1;
        chk("oor_reg3", pk(r1v), lv(1, B, 3, D));
        tick();
        chk("oor_drop_clr", wr_drop, 1'b0);

        for (int r = 0; r < NR; r++) begin
            wren = 1'b1; wraddr = AW'(r); wrmask = 4'hF;
            set_data(fv(r, 0), fv(r, 1), fv(r, 2), fv(r, 3));
            tick();
        end
        wren = 1'b0;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int k = 1; k <= NR; k++) begin
            chk("clr_busy", clr_busy, 1'b1);
            if (k == 1) begin
                chk("clr_no_done", clr_done, 1'b0);
            end
            if (k == 2) begin
                wren = 1'b1; wraddr = 4'd0; wrmask = 4'hF;
                set_data(32'h77, 32'h77, 32'h77, 32'h77);
            end
            if (k == 3) begin
                wren = 1'b0;
                chk("clr_wr_drop", wr_drop, 1'b1);
                clr_start = 1'b1;
            end
            if (k == 4) begin
                clr_start = 1'b0;
                readAddr1 = 4'd8; readAddr2 = 4'd2;
                #1;
                chk("clr_old_r8", pk(r1v), lv(fv(8, 0), fv(8, 1), fv(8, 2), fv(8, 3)));
                chk("clr_done_r2", pk(r2v), lv(0, 0, 0, 0));
                readAddr1 = 4'd3;
                #1;
                chk("clr_old_r3", pk(r1v), lv(fv(3, 0), fv(3, 1), fv(3, 2), fv(3, 3)));
            end
            tick();
        end
        chk("clr_end_busy", clr_busy, 1'b0);
        chk("clr_done_pulse", clr_done, 1'b1);
        readAddr1 = 4'd0;
        #1;
        chk("clr_r0_zero", pk(r1v), lv(0, 0, 0, 0));
        wren = 1'b1; wraddr = 4'd8; wrmask = 4'hF;
        set_data(32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003);
        clr_start = 1'b1;
        tick();
        wren = 1'b0; clr_start = 1'b0;
        chk("restart_done_low", clr_done, 1'b0);
        chk("restart_busy", clr_busy, 1'b1);
        readAddr2 = 4'd8;
        for (int r = 0; r < NR - 1; r++) begin
            readAddr1 = AW'(r);
            #1;
            chk("clr_all_zero", pk(r1v), lv(0, 0, 0, 0));
        end
        chk("start_cycle_write", pk(r2v),
            lv(32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003));

        tick();
        tick();
        readAddr1 = 4'd8;
        #1;
        chk("mid_r8_old", pk(r1v),
            lv(32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", clr_busy, 1'b0);
        chk("midrst_done", clr_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_clr = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (clr_done || clr_busy) saw_clr = 1'b1;
        end
        chk("midrst_no_done", saw_clr, 1'b0);
        readAddr1 = 4'd8;
        #1;
        chk("midrst_r8_zero", pk(r1v), lv(0, 0, 0, 0));

        test_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vreg_file_masked.md
Name: vreg_file_masked

Overview:
- Parametrised next-generation vector register file for the vector CPU datapath. It sits between decode/operand-fetch and the writeback stage.
- Provides NUM_REGS registers, each LANES lanes of WIDTH bits, with two combinational read ports and one synchronous write port.
- Adds per-lane write masking, optional write-to-read bypass, out-of-range address protection, and a sequential bulk-clear engine that zeroes one register per cycle.

Parameters:
- NUM_REGS, 9, number of vector registers (must be 2 or more).
- LANES, 4, lanes per vector register.
- WIDTH, 32, bits per lane.
- AW, 4, address width (2**AW must be at least NUM_REGS).
- BYPASS, 1, 1 = read ports forward same-cycle accepted write data; 0 = read stored contents only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wren  in  1  write request.
- wraddr  in  AW  write register address.
- wrdata  in  LANES x WIDTH (unpacked array [LANES-1:0])  write vector.
- wrmask  in  LANES  per-lane write enable; bit i gates lane i.
- readAddr1  in  AW  read port 1 address.
- readAddr2  in  AW  read port 2 address.
- r1v  out  LANES x WIDTH (unpacked array [0:LANES-1])  read port 1 data.
- r2v  out  LANES x WIDTH (unpacked array [0:LANES-1])  read port 2 data.
- clr_start  in  1  request a bulk clear of all registers.
- clr_busy  out  1  bulk clear in progress.
- clr_done  out  1  one-cycle pulse when bulk clear completes.
- wr_drop  out  1  registered pulse: the previous cycle's write request was discarded.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers and lanes clear to 0.
  - FSM goes to IDLE and the clear counter goes to 0.
  - clr_busy=0, clr_done=0, wr_drop=0.
  - r1v and r2v read 0 while reset is held.
- Write acceptance:
  - A write is accepted when wren=1, clr_busy=0 and wraddr<NUM_REGS.
  - On the rising edge, lane i of regs[wraddr] takes wrdata[i] only if wrmask[i]=1. Other lanes hold.
  - wrmask=0 with wren=1 is accepted but changes nothing. It is not a drop.
- wr_drop is set to 1 on the edge following either:
  - wren=1 with wraddr>=NUM_REGS, or
  - wren=1 while clr_busy=1.
  - Otherwise wr_drop is 0. Dropped writes never modify state.
- Reads (combinational, zero latency):
  - rNv = regs[readAddrN].
  - readAddrN>=NUM_REGS returns all-zero lanes.
  - Both ports may read the same address.
- Bypass (BYPASS=1 only):
  - Applies when a write is accepted this cycle and readAddrN==wraddr.
  - Lanes with wrmask[i]=1 show wrdata[i]; the other lanes show stored data.
  - With BYPASS=0, new data becomes visible the cycle after the edge.
- Clear FSM, states IDLE and CLEAR:
  - In IDLE, clr_start=1 moves to CLEAR and sets cnt=0. A write accepted in that same cycle completes normally.
  - In CLEAR: clr_busy=1, and each edge writes all lanes of regs[cnt] to 0, then cnt increments.
  - When cnt==NUM_REGS-1, that edge clears the last register, the FSM returns to IDLE, and clr_done=1 for exactly the next cycle.
  - Total clear occupancy is NUM_REGS cycles, with clr_busy high for those cycles.
  - clr_start while in CLEAR is ignored and does not restart the sequence.
  - clr_start in the cycle clr_done=1 (now IDLE) starts a new clear.
  - Reads stay functional during CLEAR and return current contents: already-cleared registers read 0, pending ones read their old values.
  - Bypass never applies during CLEAR, since no write is accepted.
- Reset mid-clear aborts immediately. All registers are 0 anyway, FSM is IDLE, and clr_done is not pulsed.
- Width rules: cnt is AW bits. No arithmetic on data; the block is storage only.

Test Plan:
- Reset then read: hold rst_n=0 with readAddr1=0 and readAddr2=8 -> r1v and r2v are all 0. Release reset -> outputs stay 0.
- Masked write: write wraddr=3, wrdata={A,B,C,D}, wrmask=4'b1111. Next cycle write wraddr=3, wrdata={1,2,3,4}, wrmask=4'b0101 -> regs[3] lanes = {1,B,3,D}; wr_drop=0.
- Bypass: BYPASS=1, wren=1, wraddr=5, wrmask=4'b0011, wrdata lanes 0..1 = 0xFFFF_FFFF, readAddr1=5 with stored lanes all 0x11 -> r1v in the same cycle = {0xFFFF_FFFF, 0xFFFF_FFFF, 0x11, 0x11}. With BYPASS=0 the same stimulus shows all-0x11 until the next cycle.
- Out-of-range access: wren=1, wraddr=12 (NUM_REGS=9) -> no register changes and wr_drop=1 on the next cycle. readAddr2=12 -> r2v=0.
- Bulk clear: fill regs 0..8 with nonzero data, pulse clr_start -> clr_busy=1 for 9 cycles and regs clear in order 0..8. During the clear:
  - Reading reg 8 at cycle 4 returns the old value.
  - A write during the clear is dropped (wr_drop=1).
  - A second clr_start is ignored.
  - clr_done pulses once, then all reads return 0.
- Reset mid-clear: assert rst_n=0 at clear cycle 3 -> immediately clr_busy=0 and all regs 0. No clr_done pulse after release.
